// File: rtl/snes_multi_reader.sv
// Polls NUM_PADS SNES-style controllers over a shared latch/clock pair and
// publishes one parallel button word per pad, with a valid strobe and change flags.
//
// state | meaning
// IDLE  | waiting for start (or auto-poll gap expiry)
// LATCH | latch pulse high, serial clock high, 2*CLK_DIV cycles
// LOW   | serial clock low, data sampled on the last cycle
// HIGH  | serial clock high, pads shift on the rising edge
// DONE  | publish all words in one cycle
module snes_multi_reader #(
  parameter int NUM_PADS   = 2,
  parameter int BITS       = 16,
  parameter int CLK_DIV    = 5,
  parameter int ACTIVE_LOW = 1,
  parameter int AUTO_POLL  = 0,
  parameter int POLL_GAP   = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_PADS-1:0]      pad_data,
  output logic                     snes_clk,
  output logic                     snes_latch,
  output logic [NUM_PADS*BITS-1:0] buttons,
  output logic                     valid,
  output logic [NUM_PADS-1:0]      changed,
  output logic                     busy
);

  localparam int BW = $clog2(BITS + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            shift_en;
  logic            publish;
  logic            div_last;
  logic [BITS-1:0] shift_q [NUM_PADS];

  assign div_last = (div_q == DIV_LAST);
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    shift_en = 1'b0;
    publish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start || (AUTO_POLL != 0 && gap_q == GAP_LAST)) begin
          state_d = S_LATCH;
          gap_d   = '0;
          div_d   = '0;
          bit_d   = '0;
        end else if (AUTO_POLL != 0) begin
          gap_d = gap_q + GW'(1);
        end
      end
      // The latch spans two divider periods; bit_q marks which half we are in.
      S_LATCH: begin
        if (div_last) begin
          div_d = '0;
          if (bit_q == BW'(1)) begin
            state_d = S_LOW;
            bit_d   = '0;
          end else begin
            bit_d = BW'(1);
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_LOW: begin
        if (div_last) begin
          div_d    = '0;
          shift_en = 1'b1;
          state_d  = S_HIGH;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_HIGH: begin
        if (div_last) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_DONE;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + BW'(1);
            state_d = S_LOW;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_DONE: begin
        publish = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
    end
  end

  // Pad pins are decoded from the next state so they line up with state_q exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snes_clk   <= 1'b1;
      snes_latch <= 1'b0;
    end else begin
      snes_clk   <= (state_d != S_LOW);
      snes_latch <= (state_d == S_LATCH);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PADS; p++) shift_q[p] <= '0;
    end else if (shift_en) begin
      for (int p = 0; p < NUM_PADS; p++)
        shift_q[p] <= (shift_q[p] << 1) | BITS'(pad_data[p]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buttons <= '0;
      changed <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= publish;
      if (publish) begin
        for (int p = 0; p < NUM_PADS; p++) begin
          buttons[p*BITS +: BITS] <= (ACTIVE_LOW != 0) ? ~shift_q[p] : shift_q[p];
          changed[p] <= (((ACTIVE_LOW != 0) ? ~shift_q[p] : shift_q[p])
                         != buttons[p*BITS +: BITS]);
        end
      end
    end
  end

endmodule

// File: tb/tb_snes_multi_reader.sv
// Bench for snes_multi_reader: behavioural pad models, table vectors, random polls,
// waveform timing, reset abort, busy-start rejection and auto-poll spacing.
module tb_snes_multi_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start_a;
  logic [1:0]  pad_data, pad_data_a;
  logic        snes_clk, snes_latch, valid, busy;
  logic [31:0] buttons;
  logic [1:0]  changed;
  logic        snes_clk_a, snes_latch_a, valid_a, busy_a;
  logic [31:0] buttons_a;
  logic [1:0]  changed_a;

  always #5 clk = ~clk;

  snes_multi_reader #(.NUM_PADS(2), .BITS(16), .CLK_DIV(5), .ACTIVE_LOW(1),
                      .AUTO_POLL(0), .POLL_GAP(1000)) dut (
    .clk(clk), .reset(rst), .start(start), .pad_data(pad_data),
    .snes_clk(snes_clk), .snes_latch(snes_latch), .buttons(buttons),
    .valid(valid), .changed(changed), .busy(busy));

  snes_multi_reader #(.NUM_PADS(2), .BITS(16), .CLK_DIV(5), .ACTIVE_LOW(1),
                      .AUTO_POLL(1), .POLL_GAP(20)) dut_a (
    .clk(clk), .reset(rst), .start(start_a), .pad_data(pad_data_a),
    .snes_clk(snes_clk_a), .snes_latch(snes_latch_a), .buttons(buttons_a),
    .valid(valid_a), .changed(changed_a), .busy(busy_a));

  // Pad model: latch rewinds to the first bit, each serial-clock rise advances one bit.
  logic [15:0] raw [2];
  logic [15:0] raw_a [2];
  int idx = 16, idx_a = 16;
  always @(posedge snes_latch) idx = 0;
  always @(posedge snes_clk) begin #1; idx = idx + 1; end
  always @(posedge snes_latch_a) idx_a = 0;
  always @(posedge snes_clk_a) begin #1; idx_a = idx_a + 1; end
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      pad_data[p]   = (idx   < 16) ? raw[p][15-idx]     : 1'b1;
      pad_data_a[p] = (idx_a < 16) ? raw_a[p][15-idx_a] : 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One poll window of 400 cycles, measuring everything observable on the pins.
  task automatic poll(input bit extra_start, output int lat, output int nvalid,
                      output int latch_cyc, output int low_pulses, output int bad_low);
    int run;
    lat = 0; nvalid = 0; latch_cyc = 0; low_pulses = 0; bad_low = 0; run = 0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      start = extra_start && (n == 50 || n == 150);
      if (snes_latch) latch_cyc++;
      if (!snes_clk) run++;
      else if (run > 0) begin
        low_pulses++;
        if (run != 5) bad_low++;
        run = 0;
      end
      if (valid) begin
        nvalid++;
        if (lat == 0) lat = n;
      end
    end
  endtask

  task automatic wait_va(output int t);
    t = -1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (valid_a) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      errors++;
      $display("FAIL auto_valid_timeout: got none expected strobe");
    end
  endtask

  typedef struct {
    logic [15:0] r0, r1;
    logic [31:0] exp_btn;
    logic [1:0]  exp_chg;
  } vec_t;

  vec_t vecs [4];
  logic [15:0] prev [2];
  logic [15:0] expw [2];
  logic [1:0]  expc;
  int lat, nv, lc, lp, bl;
  int t0, t1, t2, t3;

  initial begin
    vecs[0] = '{16'hFFF5, 16'hFFFD, 32'h0002_000A, 2'b11};
    vecs[1] = '{16'hFFF5, 16'hFFFD, 32'h0002_000A, 2'b00};
    vecs[2] = '{16'hFFFF, 16'hFFFD, 32'h0002_0000, 2'b01};
    vecs[3] = '{16'h0000, 16'h7FFE, 32'h8001_FFFF, 2'b11};

    rst = 1'b1; start = 1'b0; start_a = 1'b0;
    raw[0] = 16'hFFFF; raw[1] = 16'hFFFF;
    raw_a[0] = 16'hFF00; raw_a[1] = 16'hF0F0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_buttons", buttons, 0);
    chk("reset_snes_clk", snes_clk, 1);
    chk("reset_latch", snes_latch, 0);
    chk("reset_valid", valid, 0);
    chk("reset_changed", changed, 0);
    rst = 1'b0;

    // Table vectors, with full pin timing on every poll.
    for (int i = 0; i < 4; i++) begin
      raw[0] = vecs[i].r0; raw[1] = vecs[i].r1;
      poll(1'b0, lat, nv, lc, lp, bl);
      chk($sformatf("vec%0d_buttons", i), buttons, vecs[i].exp_btn);
      chk($sformatf("vec%0d_changed", i), changed, vecs[i].exp_chg);
      chk($sformatf("vec%0d_nvalid", i), nv, 1);
      chk($sformatf("vec%0d_latency", i), lat, 172);
      chk($sformatf("vec%0d_latch_cycles", i), lc, 10);
      chk($sformatf("vec%0d_low_pulses", i), lp, 16);
      chk($sformatf("vec%0d_bad_low_len", i), bl, 0);
      chk($sformatf("vec%0d_busy_end", i), busy, 0);
    end

    // Reset during bit 7 aborts immediately.
    raw[0] = 16'h1234; raw[1] = 16'hABCD;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (84) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_latch", snes_latch, 0);
    chk("abort_snes_clk", snes_clk, 1);
    chk("abort_buttons", buttons, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    @(negedge clk); rst = 1'b0;
    poll(1'b0, lat, nv, lc, lp, bl);
    chk("after_abort_buttons", buttons, {~16'hABCD, ~16'h1234});
    chk("after_abort_changed", changed, 2'b11);
    chk("after_abort_nvalid", nv, 1);
    prev[0] = ~16'h1234; prev[1] = ~16'hABCD;

    // Random polls against the reference model.
    for (int k = 0; k < 10; k++) begin
      if (k % 3 != 2) begin
        raw[0] = 16'($urandom); raw[1] = 16'($urandom);
      end
      for (int p = 0; p < 2; p++) begin
        expw[p] = ~raw[p];
        expc[p] = (expw[p] != prev[p]);
        prev[p] = expw[p];
      end
      poll(1'b0, lat, nv, lc, lp, bl);
      chk($sformatf("rand%0d_buttons", k), buttons, {expw[1], expw[0]});
      chk($sformatf("rand%0d_changed", k), changed, expc);
      chk($sformatf("rand%0d_nvalid", k), nv, 1);
    end

    // Start while busy is ignored.
    raw[0] = 16'h5A5A; raw[1] = 16'h0F0F;
    poll(1'b1, lat, nv, lc, lp, bl);
    chk("busy_start_nvalid", nv, 1);
    chk("busy_start_latch_cycles", lc, 10);
    chk("busy_start_low_pulses", lp, 16);
    chk("busy_start_buttons", buttons, {~16'h0F0F, ~16'h5A5A});

    // Auto-poll spacing and change tracking.
    wait_va(t0);
    wait_va(t1);
    chk("auto_interval_steady", t1 - t0, 191);
    chk("auto_changed_steady", changed_a, 2'b00);
    raw_a[0] = 16'h00FF;
    wait_va(t2);
    chk("auto_interval_change", t2 - t1, 191);
    chk("auto_changed_after", changed_a, 2'b01);
    chk("auto_buttons", buttons_a, {~16'hF0F0, ~16'h00FF});
    wait_va(t3);
    chk("auto_interval_next", t3 - t2, 191);
    chk("auto_changed_settled", changed_a, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
